// File: rtl/ll_dma_host.sv
`timescale 1ns/1ps
// LocalLink DMA-side host: sources one TX frame and sinks/checks the echoed RX frame.
// Optional handshake throttling is enabled by defining LL_HOST_THROTTLE_EN.
//
// state  | meaning
// T_IDLE | no TX frame in flight
// T_HDR  | sending header words (SOF on word 0)
// T_PAY  | sending payload seed+k (SOP/EOP, REM on last)
// T_FTR  | sending zero footer words (EOF on last)
// R_IDLE | waiting for the first RX beat (must carry SOF+SOP)
// R_PAY  | checking echoed payload against seed+j
// R_TRL  | counting trailer beats, capturing status and length
// R_DONE | RX frame closed, waiting for TX to finish
module ll_dma_host #(
    parameter int HDR_WORDS = 8,
    parameter int FLAG_IDX  = 4,
    parameter int LEN_IDX   = 5,
    parameter int FTR_WORDS = 8,
    parameter int STS_IDX   = 3,
    parameter int RLEN_IDX  = 4
) (
    input  logic        CPMDMALLCLK,
    input  logic        CPMDMALLRSTN,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] len,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] mis_cnt,
    output logic        cpl_status,
    output logic [31:0] rlen,
    output logic [31:0] DMALLTXD,
    output logic [3:0]  DMALLTXREM,
    output logic        DMALLTXSOFN,
    output logic        DMALLTXEOFN,
    output logic        DMALLTXSOPN,
    output logic        DMALLTXEOPN,
    output logic        DMALLTXSRCRDYN,
    input  logic        LLDMATXDSTRDYN,
    input  logic [31:0] LLDMARXD,
    input  logic [3:0]  LLDMARXREM,
    input  logic        LLDMARXSOFN,
    input  logic        LLDMARXEOFN,
    input  logic        LLDMARXSOPN,
    input  logic        LLDMARXEOPN,
    input  logic        LLDMARXSRCRDYN,
    output logic        DMALLRXDSTRDYN
);
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY, T_FTR} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_PAY, R_TRL, R_DONE} rx_state_t;

    tx_state_t   tx_state, tx_nxt;
    rx_state_t   rx_state, rx_nxt;
    logic [29:0] tx_cnt, rx_cnt, nw_q;
    logic [7:0]  trl_cnt;
    logic [2:0]  op_q;
    logic [31:0] len_q, seed_q;
    logic [3:0]  exp_rem;
    logic [31:0] byte_mask, exp_word;
    logic        start_ok, done_w, tx_beat, rx_beat, pay_last, rx_err, mis_inc;
    logic        tx_active, rx_rdy;

    assign start_ok  = start & ~busy;
    assign done_w    = busy & (tx_state == T_IDLE) & (rx_state == R_DONE);
    assign done      = done_w;
    assign tx_active = (tx_state != T_IDLE);
    assign rx_rdy    = busy & (rx_state != R_DONE);
    assign tx_beat   = ~DMALLTXSRCRDYN & ~LLDMATXDSTRDYN;
    assign rx_beat   = ~LLDMARXSRCRDYN & ~DMALLRXDSTRDYN;
    assign pay_last  = (tx_cnt == nw_q - 30'd1);

`ifdef LL_HOST_THROTTLE_EN
    logic [15:0] lfsr;
    always_ff @(posedge CPMDMALLCLK or negedge CPMDMALLRSTN) begin
        if (!CPMDMALLRSTN) lfsr <= 16'hACE1;
        else               lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    assign DMALLTXSRCRDYN = ~tx_active | lfsr[0];
    assign DMALLRXDSTRDYN = ~rx_rdy | lfsr[5];
`else
    assign DMALLTXSRCRDYN = ~tx_active;
    assign DMALLRXDSTRDYN = ~rx_rdy;
`endif

    // REM bit 0 masks byte [31:24], so partial words keep their low bytes
    always_comb begin
        case (len_q[1:0])
            2'd0:    exp_rem = 4'b0000;
            2'd1:    exp_rem = 4'b0111;
            2'd2:    exp_rem = 4'b0011;
            default: exp_rem = 4'b0001;
        endcase
    end

    always_comb begin
        tx_nxt      = tx_state;
        DMALLTXD    = 32'd0;
        DMALLTXREM  = 4'd0;
        DMALLTXSOFN = 1'b1;
        DMALLTXEOFN = 1'b1;
        DMALLTXSOPN = 1'b1;
        DMALLTXEOPN = 1'b1;
        case (tx_state)
            T_IDLE: if (start_ok && len != 32'd0) tx_nxt = T_HDR;
            T_HDR: begin
                DMALLTXSOFN = (tx_cnt != 30'd0);
                if (tx_cnt == 30'(FLAG_IDX))     DMALLTXD = {op_q, 29'd0};
                else if (tx_cnt == 30'(LEN_IDX)) DMALLTXD = len_q;
                if (tx_beat && tx_cnt == 30'(HDR_WORDS - 1)) tx_nxt = T_PAY;
            end
            T_PAY: begin
                DMALLTXD    = seed_q + {2'b00, tx_cnt};
                DMALLTXSOPN = (tx_cnt != 30'd0);
                DMALLTXEOPN = ~pay_last;
                DMALLTXREM  = pay_last ? exp_rem : 4'd0;
                if (tx_beat && pay_last) tx_nxt = T_FTR;
            end
            default: begin
                DMALLTXEOFN = (tx_cnt != 30'(FTR_WORDS - 1));
                if (tx_beat && tx_cnt == 30'(FTR_WORDS - 1)) tx_nxt = T_IDLE;
            end
        endcase
    end

    always_ff @(posedge CPMDMALLCLK or negedge CPMDMALLRSTN) begin
        if (!CPMDMALLRSTN) begin
            tx_state <= T_IDLE;
            tx_cnt   <= 30'd0;
        end else begin
            tx_state <= tx_nxt;
            if (tx_nxt != tx_state) tx_cnt <= 30'd0;
            else if (tx_beat)       tx_cnt <= tx_cnt + 30'd1;
        end
    end

    assign exp_word  = seed_q + {2'b00, rx_cnt};
    assign byte_mask = LLDMARXEOPN ? 32'hFFFF_FFFF :
                       {{8{~exp_rem[0]}}, {8{~exp_rem[1]}}, {8{~exp_rem[2]}}, {8{~exp_rem[3]}}};

    always_comb begin
        rx_nxt  = rx_state;
        rx_err  = 1'b0;
        mis_inc = 1'b0;
        case (rx_state)
            R_IDLE, R_PAY: begin
                if (rx_state == R_IDLE && start_ok && len == 32'd0) begin
                    rx_nxt = R_DONE;
                end else if (rx_beat) begin
                    if (rx_state == R_IDLE) begin
                        if (LLDMARXSOFN || LLDMARXSOPN) rx_err = 1'b1;
                        rx_nxt = R_PAY;
                    end else if (!LLDMARXSOFN) begin
                        rx_err = 1'b1;
                    end
                    if (|((LLDMARXD ^ exp_word) & byte_mask)) begin
                        mis_inc = 1'b1;
                        rx_err  = 1'b1;
                    end
                    if (!LLDMARXEOPN) begin
                        rx_nxt = R_TRL;
                        if (rx_cnt + 30'd1 != nw_q || LLDMARXREM != exp_rem) rx_err = 1'b1;
                    end
                end
            end
            R_TRL: if (rx_beat) begin
                if (!LLDMARXSOFN) rx_err = 1'b1;
                if (trl_cnt == 8'(STS_IDX) && LLDMARXD[31:29] != op_q) rx_err = 1'b1;
                if (trl_cnt == 8'(RLEN_IDX) && LLDMARXD != len_q) rx_err = 1'b1;
                if (!LLDMARXEOFN) begin
                    rx_nxt = R_DONE;
                    if (trl_cnt < 8'(RLEN_IDX)) rx_err = 1'b1;
                end
            end
            default: if (done_w) rx_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge CPMDMALLCLK or negedge CPMDMALLRSTN) begin
        if (!CPMDMALLRSTN) begin
            rx_state   <= R_IDLE;
            rx_cnt     <= 30'd0;
            trl_cnt    <= 8'd0;
            cpl_status <= 1'b0;
            rlen       <= 32'd0;
        end else begin
            rx_state <= rx_nxt;
            if (start_ok) begin
                rx_cnt  <= 30'd0;
                trl_cnt <= 8'd0;
            end else if (rx_beat) begin
                if (rx_state == R_IDLE || rx_state == R_PAY) rx_cnt <= rx_cnt + 30'd1;
                if (rx_state == R_TRL) begin
                    if (trl_cnt != 8'hFF) trl_cnt <= trl_cnt + 8'd1;
                    if (trl_cnt == 8'(STS_IDX))  cpl_status <= LLDMARXD[28];
                    if (trl_cnt == 8'(RLEN_IDX)) rlen <= LLDMARXD;
                end
            end
        end
    end

    always_ff @(posedge CPMDMALLCLK or negedge CPMDMALLRSTN) begin
        if (!CPMDMALLRSTN) begin
            busy    <= 1'b0;
            err     <= 1'b0;
            mis_cnt <= 16'd0;
            op_q    <= 3'd0;
            len_q   <= 32'd0;
            seed_q  <= 32'd0;
            nw_q    <= 30'd0;
        end else if (start_ok) begin
            busy    <= 1'b1;
            err     <= (len == 32'd0);
            mis_cnt <= 16'd0;
            op_q    <= op;
            len_q   <= len;
            seed_q  <= seed;
            nw_q    <= 30'((len + 32'd3) >> 2);
        end else begin
            if (done_w) busy <= 1'b0;
            if (rx_err) err <= 1'b1;
            if (mis_inc && mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
        end
    end
endmodule

// File: doc/ll_dma_host.md
Name: ll_dma_host

Overview:
- Synthesizable DMA-side LocalLink endpoint for the compression unit.
- Plays the DMA engine: sources one TX frame (8 header words, payload, footer) into the unit's TX port, then sinks the returned RX frame (echoed payload plus status trailer).
- Checks the echoed payload against a regenerated pattern and reports status.
- Used in the self-test wrapper and at board bring-up, in place of the hard DMA.

Parameters:
- HDR_WORDS, 8: TX header words; word 0 carries SOF.
- FLAG_IDX, 4: header index carrying op flags in bits [31:29]; all other bits and other header words are 0.
- LEN_IDX, 5: header index carrying the byte length.
- FTR_WORDS, 8: TX footer words after EOP; the last one carries EOF.
- STS_IDX, 3: RX trailer index (0 = first beat after EOP) holding {flag[31:29], cpl_status[28]}.
- RLEN_IDX, 4: RX trailer index holding the returned length.

Ports:
- CPMDMALLCLK  in  1  single clock.
- CPMDMALLRSTN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; ignored while busy.
- op  in  3  flags {comp, decomp, copy}.
- len  in  32  payload byte count.
- seed  in  32  payload word 0 value.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when both frames complete.
- err  out  1  sticky until next start: mismatch, length error or framing error.
- mis_cnt  out  16  payload mismatch count, saturating.
- cpl_status  out  1  bit 28 of the trailer status word.
- rlen  out  32  captured returned length.
- DMALLTXD/REM/SOFN/EOFN/SOPN/EOPN/SRCRDYN  out  32/4/1/1/1/1/1  TX LocalLink source.
- LLDMATXDSTRDYN  in  1  TX destination ready.
- LLDMARXD/REM/SOFN/EOFN/SOPN/EOPN/SRCRDYN  in  32/4/1/1/1/1/1  RX LocalLink sink.
- DMALLRXDSTRDYN  out  1  RX destination ready.

Behaviour:
- Reset values:
  - All active-low LocalLink outputs = 1; DMALLTXD = 0; DMALLTXREM = 0.
  - busy = 0, done = 0, err = 0, mis_cnt = 0, cpl_status = 0, rlen = 0.
  - Both state machines go to IDLE.
- Reset mid-frame aborts immediately; there is no frame close-out.
- Beat transfer: a beat moves when SRCRDYN = 0 and DSTRDYN = 0 in the same cycle. Data and flags stay stable while stalled.
- Start:
  - On start with busy = 0: latch op, len and seed; compute nw = (len+3)>>2 as a 30-bit value; set busy; clear err and mis_cnt.
  - If len = 0: no frame is sent, err = 1, and done pulses 1 cycle after start.
- TX FSM, T_IDLE -> T_HDR -> T_PAY -> T_FTR -> T_IDLE:
  - T_HDR: sends HDR_WORDS beats; SOFN = 0 on beat 0 only.
  - T_PAY: word k = seed + k (mod 2^32); SOPN = 0 on k = 0; EOPN = 0 on k = nw-1.
  - Last-word REM from len[1:0]: 0 -> 0000, 3 -> 0001, 2 -> 0011, 1 -> 0111. REM = 0000 on every other beat.
  - nw = 1: SOPN and EOPN are both 0 on the same beat.
  - T_FTR: sends FTR_WORDS zero beats; EOFN = 0 on the last one.
  - DMALLTXSRCRDYN = 0 in T_HDR, T_PAY and T_FTR. There are no idle gaps unless throttled.
- RX FSM, R_IDLE -> R_PAY -> R_TRL -> R_DONE:
  - DMALLRXDSTRDYN = 0 whenever busy and the RX FSM is not in R_DONE.
  - R_IDLE: waits for the first beat. That beat must have SOFN = 0 and SOPN = 0, otherwise err = 1.
  - R_PAY: beat j is compared to seed + j.
    - Last beat: only valid bytes are compared, per REM (byte 3 = [31:24], masked out first).
    - Each mismatch increments mis_cnt (saturates at FFFF) and sets err.
    - EOPN = 0 moves to R_TRL. Beat count != nw, or REM != expected, sets err.
  - R_TRL: counts trailer beats.
    - At STS_IDX: capture cpl_status. Bits [31:29] != op sets err.
    - At RLEN_IDX: capture rlen. rlen != len sets err.
    - EOFN = 0 moves to R_DONE. EOFN = 0 before RLEN_IDX sets err.
  - SOFN = 0 after the first beat sets err.
  - Both FSMs idle/done: pulse done, clear busy, and both FSMs return to IDLE the next cycle.
- RX beats arriving before TX completes are accepted; the TX and RX FSMs are independent.
- A start in the same cycle as done is ignored.

Optional Feature:
- Macro LL_HOST_THROTTLE_EN.
- When defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every cycle) gates the handshakes.
  - LFSR bit 0 = 1 forces DMALLTXSRCRDYN = 1.
  - LFSR bit 5 = 1 forces DMALLRXDSTRDYN = 1.
  - Data ordering and all checks are unchanged.
- When undefined: no LFSR exists and both ready signals follow the FSMs only.

Test Plan:
- op = 3'b001, len = 16, seed = 32'h1000_0000, loopback model -> TX: 8 header beats, word 4 = 32'h2000_0000, word 5 = 16, payload 10000000..10000003 with REM 0000, 8 footer beats; RX echo plus trailer with status 32'h3000_0000 -> done, err = 0, mis_cnt = 0, cpl_status = 1, rlen = 16.
- len = 5 -> 2 payload words; last TX beat REM = 0111. A model that corrupts byte 1 of the last word -> no error (byte masked). Corrupting byte 0 instead -> mis_cnt = 1, err = 1.
- len = 4, seed = FFFFFFFF -> single payload beat with SOPN = EOPN = 0 and data FFFFFFFF. Then len = 8 -> second word wraps to 00000000.
- len = 0 -> no TX beats, done 1 cycle after start, err = 1.
- Sink holds LLDMATXDSTRDYN = 1 for 10 cycles mid-payload -> DMALLTXD is unchanged throughout; the frame completes intact. A second start while busy is ignored.
- Reset asserted during beat 3 of the payload -> all outputs at reset values asynchronously; a fresh start afterwards completes cleanly (with LL_HOST_THROTTLE_EN defined and undefined).
